// File: rtl/mul_share_arbiter_if.sv
// Bundle of requester, multiplier and response signals around mul_share_arbiter.
// master = requester array / multiplier side, slave = the arbiter itself.
interface mul_share_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*32-1:0] req_a;
    logic [N_REQ*32-1:0] req_b;
    logic [31:0]         mul_a;
    logic [31:0]         mul_b;
    logic [63:0]         mul_result;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [63:0]         rsp_result;
    logic                busy;

    modport master (
        output req_valid, req_a, req_b, mul_result, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_result, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_result, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_result, busy
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin share of one combinational 32x32 multiplier among N_REQ requesters.
// Optional MUL_ARB_B2B_EN: issue the next grant in the same cycle a response is taken.
module mul_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 2
) (
    input logic                clk,
    input logic                rst,
    mul_share_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ID_W-1:0]  r_last_grant;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_mul_a;
    logic [31:0]      r_mul_b;
    logic [ID_W-1:0]  r_rsp_id;
    logic [63:0]      r_rsp_result;

    logic [ID_W-1:0]  w_grant;
    logic             w_found;
    logic [ID_W:0]    w_idx;
    logic [ID_W-1:0]  w_cand;
    logic             w_accept;
    logic             w_cnt_done;
    logic [N_REQ-1:0] w_req_ready;

    // Round-robin search starting one past the previous winner, wrapping at N_REQ.
    always_comb begin
        w_grant = r_last_grant;
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = {1'b0, r_last_grant} + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(N_REQ)) begin
                w_idx = w_idx - (ID_W+1)'(N_REQ);
            end
            w_cand = w_idx[ID_W-1:0];
            if (!w_found && bus.req_valid[w_cand]) begin
                w_grant = w_cand;
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_cnt_done  = (r_cnt == CNT_W'(MUL_LAT - 1));
        case (r_state)
            S_IDLE: begin
                if (w_found && !rst) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_cnt_done) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
`ifdef MUL_ARB_B2B_EN
                    if (w_found && !rst) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_EXEC;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
`else
                    w_state_nxt = S_IDLE;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_req_ready = '0;
        if (w_accept) begin
            w_req_ready[w_grant] = 1'b1;
        end
    end

    // Operand capture on grant; product sampled once the multiplier inputs have settled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= ID_W'(N_REQ - 1);
            r_cnt        <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
        end else begin
            if (w_accept) begin
                r_mul_a      <= bus.req_a[32*w_grant +: 32];
                r_mul_b      <= bus.req_b[32*w_grant +: 32];
                r_rsp_id     <= w_grant;
                r_last_grant <= w_grant;
                r_cnt        <= '0;
            end else if (r_state == S_EXEC) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == S_EXEC && w_cnt_done) begin
                r_rsp_result <= bus.mul_result;
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.mul_a      = r_mul_a;
    assign bus.mul_b      = r_mul_b;
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mul_share_arbiter;
    localparam int N_REQ   = 4;
    localparam int MUL_LAT = 2;
`ifdef MUL_ARB_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_share_arbiter_if #(.N_REQ(N_REQ)) bus();
    assign bus.mul_result = 64'(bus.mul_a) * 64'(bus.mul_b);

    mul_share_arbiter #(.N_REQ(N_REQ), .MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int pcyc  = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) pcyc <= pcyc + 1;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, pcyc, act, exp);
        end
    endfunction

    // Model: at most one outstanding operation; its result is due 1+MUL_LAT cycles
    // after acceptance and stays visible until taken.
    bit          m_out  = 1'b0;
    int          m_due  = 0;
    int          m_last = N_REQ - 1;
    int          m_id   = 0;
    logic [31:0] m_a    = '0;
    logic [31:0] m_b    = '0;
    logic [63:0] m_prod = '0;

    always @(negedge clk) begin
        logic [N_REQ-1:0] e_ready;
        bit e_valid, acc;
        int g;
        if (chk_en) begin
            e_valid = m_out && (pcyc >= m_due);
            g = -1;
            for (int k = 1; k <= N_REQ; k++) begin
                if (g < 0 && bus.req_valid[(m_last + k) % N_REQ]) g = (m_last + k) % N_REQ;
            end
            acc = !rst && (g >= 0) && (!m_out || (B2B && e_valid && bus.rsp_ready));
            e_ready = '0;
            if (acc) e_ready[g] = 1'b1;
            check("req_ready", 64'(bus.req_ready), 64'(e_ready));
            check("rsp_valid", 64'(bus.rsp_valid), 64'(e_valid));
            check("busy", 64'(bus.busy), 64'(m_out));
            check("mul_a", 64'(bus.mul_a), 64'(m_a));
            check("mul_b", 64'(bus.mul_b), 64'(m_b));
            if (e_valid) begin
                check("rsp_id", 64'(bus.rsp_id), 64'(m_id));
                check("rsp_result", bus.rsp_result, m_prod);
            end
            if (rst) begin
                m_out = 1'b0; m_last = N_REQ - 1; m_id = 0; m_a = '0; m_b = '0;
            end else begin
                if (e_valid && bus.rsp_ready) m_out = 1'b0;
                if (acc) begin
                    m_out  = 1'b1;
                    m_due  = pcyc + 1 + MUL_LAT;
                    m_last = g;
                    m_id   = g;
                    m_a    = bus.req_a[32*g +: 32];
                    m_b    = bus.req_b[32*g +: 32];
                    m_prod = 64'(m_a) * 64'(m_b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b, output int acc_cyc);
        bit got = 1'b0;
        bus.req_valid[idx] = 1'b1;
        bus.req_a[32*idx +: 32] = a;
        bus.req_b[32*idx +: 32] = b;
        acc_cyc = -1;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready[idx]) begin got = 1'b1; acc_cyc = pcyc; end
            tick();
        end
        bus.req_valid[idx] = 1'b0;
        check("issue_granted", 64'(got), 64'd1);
    endtask

    task automatic wait_rsp(output int rcyc, output int id, output logic [63:0] res, output bit bsy);
        bit got = 1'b0;
        rcyc = -1; id = -1; res = '0; bsy = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got = 1'b1; rcyc = pcyc; id = int'(bus.rsp_id); res = bus.rsp_result; bsy = bus.busy;
            end
            tick();
        end
        check("rsp_arrived", 64'(got), 64'd1);
    endtask

    task automatic drain();
        bit idle = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 30 && !idle; i++) begin
            @(negedge clk);
            if (!bus.busy) idle = 1'b1;
            else tick();
        end
        check("drain_idle", 64'(idle), 64'd1);
        tick();
    endtask

    task automatic pulse_rst();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int t, r, id, c0;
        logic [63:0] res, res0;
        bit bsy, g0;
        int grants[$];
        int rids[$];
        int rcyc[$];
        logic [63:0] rres[$];
        logic [N_REQ-1:0] rdy, pend;

        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        tick();
        chk_en = 1'b1;
        rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        check("rst_rsp_result", bus.rsp_result, 64'd0);
        check("rst_mul_a", 64'(bus.mul_a), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        tick();

        // single op 7*6
        issue(0, 32'd7, 32'd6, t);
        wait_rsp(r, id, res, bsy);
        check("t1_latency", 64'(r - t), 64'd3);
        check("t1_id", 64'(id), 64'd0);
        check("t1_result", res, 64'd42);
        check("t1_busy", 64'(bsy), 64'd1);
        drain();

        // max operands
        issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t);
        wait_rsp(r, id, res, bsy);
        check("t2_id", 64'(id), 64'd1);
        check("t2_result", res, 64'hFFFF_FFFE_0000_0001);
        drain();

        // fairness with all requesters held valid
        pulse_rst();
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_a[32*i +: 32] = 32'(i + 2);
            bus.req_b[32*i +: 32] = 32'(10 + i);
        end
        bus.req_valid = '1;
        for (int c = 0; c < 80 && rids.size() < 8; c++) begin
            @(negedge clk);
            for (int i = 0; i < N_REQ; i++) if (bus.req_ready[i]) grants.push_back(i);
            if (bus.rsp_valid && bus.rsp_ready) begin
                rids.push_back(int'(bus.rsp_id)); rcyc.push_back(pcyc); rres.push_back(bus.rsp_result);
            end
            tick();
            if (grants.size() >= 8) bus.req_valid = '0;
        end
        check("t3_rsp_count", 64'(rids.size()), 64'd8);
        check("t3_grant_count", 64'(grants.size()), 64'd8);
        for (int k = 0; k < 8 && k < rids.size() && k < grants.size(); k++) begin
            check("t3_grant_order", 64'(grants[k]), 64'(k % 4));
            check("t3_rsp_id", 64'(rids[k]), 64'(k % 4));
            check("t3_rsp_result", rres[k], 64'((rids[k] + 2) * (10 + rids[k])));
            if (k > 0) check("t3_interval", 64'(rcyc[k] - rcyc[k-1]), B2B ? 64'd3 : 64'd4);
        end
        drain();

        // wrap: last grant was 3, requesters 1 and 2 compete
        grants.delete();
        bus.req_a[63:32] = 32'd11; bus.req_b[63:32] = 32'd13;
        bus.req_a[95:64] = 32'd17; bus.req_b[95:64] = 32'd19;
        bus.req_valid = 4'b0110;
        for (int c = 0; c < 40 && grants.size() < 2; c++) begin
            @(negedge clk);
            for (int i = 0; i < N_REQ; i++) if (bus.req_ready[i]) grants.push_back(i);
            tick();
            for (int i = 0; i < grants.size(); i++) bus.req_valid[grants[i]] = 1'b0;
        end
        check("t4_grant_count", 64'(grants.size()), 64'd2);
        if (grants.size() == 2) begin
            check("t4_first", 64'(grants[0]), 64'd1);
            check("t4_second", 64'(grants[1]), 64'd2);
        end
        drain();

        // backpressure held in RESP
        bus.rsp_ready = 1'b0;
        issue(3, 32'h1234_5678, 32'h9ABC_DEF0, t);
        bus.req_valid[0] = 1'b1;
        bus.req_a[31:0] = 32'd3; bus.req_b[31:0] = 32'd5;
        wait_rsp(r, id, res0, bsy);
        check("t5_result", res0, 64'h1234_5678 * 64'h9ABC_DEF0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5_hold_valid", 64'(bus.rsp_valid), 64'd1);
            check("t5_hold_id", 64'(bus.rsp_id), 64'd3);
            check("t5_hold_result", bus.rsp_result, res0);
            check("t5_hold_ready", 64'(bus.req_ready), 64'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("t5_release_ready", 64'(bus.req_ready), B2B ? 64'd1 : 64'd0);
        g0 = bus.req_ready[0];
        tick();
        if (g0) bus.req_valid[0] = 1'b0;
        @(negedge clk);
        check("t5_released", 64'(bus.rsp_valid), 64'd0);
        if (!g0) begin
            check("t5_idle_grant", 64'(bus.req_ready), 64'd1);
            tick();
            bus.req_valid[0] = 1'b0;
        end
        drain();

        // reset while in EXEC
        issue(2, 32'd5, 32'd9, t);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_busy", 64'(bus.busy), 64'd0);
        check("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("t6_mul_a", 64'(bus.mul_a), 64'd0);
        check("t6_mul_b", 64'(bus.mul_b), 64'd0);
        tick();
        bus.req_valid = '1;
        @(negedge clk);
        check("t6_first_grant", 64'(bus.req_ready), 64'd1);
        tick();
        drain();

        // randomized traffic obeying the hold-until-ready rule
        pend = '0;
        rdy = '0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            rdy = bus.req_ready;
            tick();
            rst = ($urandom_range(0, 199) == 0);
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N_REQ; i++) begin
                if (rdy[i]) pend[i] = 1'b0;
                if (pend[i] && $urandom_range(0, 29) == 0) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    bus.req_a[32*i +: 32] = rnd_op();
                    bus.req_b[32*i +: 32] = rnd_op();
                end
                bus.req_valid[i] = pend[i];
            end
        end
        rst = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
